fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_if.sv | 40 ++++
 rtl/fetch_stage.sv | 152 +++++++++++++++
 tb/tb_fetch_stage.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
// Instruction-cache request/response bus between the fetch stage and the
// icache. Each direction is a valid/ready handshake.
//   icache_req_valid   fetch -> icache   request valid
//   icache_req_addr    fetch -> icache   fetch address
//   icache_req_ready   icache -> fetch   icache accepts the request
//   icache_resp_valid  icache -> fetch   response valid (held until taken)
//   icache_resp_instr  icache -> fetch   fetched instruction word
//   icache_resp_ready  fetch -> icache   fetch stage accepts the response
// Modports: master = fetch stage side, slave = icache side.
// ---------------------------------------------------------------------------
interface fetch_stage_if #(
    parameter int WORD_SIZE = 32
);
    logic                 icache_req_valid;
    logic [WORD_SIZE-1:0] icache_req_addr;
    logic                 icache_req_ready;
    logic                 icache_resp_valid;
    logic [WORD_SIZE-1:0] icache_resp_instr;
    logic                 icache_resp_ready;

    modport master (
        output icache_req_valid,
        output icache_req_addr,
        input  icache_req_ready,
        input  icache_resp_valid,
        input  icache_resp_instr,
        output icache_resp_ready
    );

    modport slave (
        input  icache_req_valid,
        input  icache_req_addr,
        output icache_req_ready,
        output icache_resp_valid,
        output icache_resp_instr,
        input  icache_resp_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Single-outstanding instruction fetch stage. Issues one icache request at a
// time, registers the returned instruction with its PC for the decoder, and
// squashes in-flight work on a downstream redirect.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   stall               decoder cannot take a new instruction this cycle
//   redirect            taken branch/jump resolved downstream
//   redirect_pc         redirect target (low two bits ignored)
//   icache              fetch_stage_if master: icache request/response bus
//   instr_out, pc_out   registered instruction and its PC
//   valid_out           instr_out/pc_out are valid
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter int                   WORD_SIZE = 32,
    parameter logic [WORD_SIZE-1:0] BOOT_PC   = 32'h0000_1000,
    parameter logic [WORD_SIZE-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    fetch_stage_if.master        icache,
    output logic [WORD_SIZE-1:0] instr_out,
    output logic [WORD_SIZE-1:0] pc_out,
    output logic                 valid_out
);

    localparam logic [1:0] ST_FETCH = 2'd0;  // may issue a request
    localparam logic [1:0] ST_WAIT  = 2'd1;  // one request outstanding
    localparam logic [1:0] ST_DRAIN = 2'd2;  // outstanding response is stale

    localparam logic [WORD_SIZE-1:0] PC_STEP = {{(WORD_SIZE-3){1'b0}}, 3'd4};

    logic [1:0]           state_r;
    logic [1:0]           state_nxt_s;
    logic [WORD_SIZE-1:0] pc_r;
    logic [WORD_SIZE-1:0] pc_nxt_s;
    logic [WORD_SIZE-1:0] instr_nxt_s;
    logic [WORD_SIZE-1:0] pc_out_nxt_s;
    logic                 valid_nxt_s;
    logic                 out_free_s;
    logic                 req_valid_s;
    logic                 resp_ready_s;
    logic                 req_hs_s;
    logic                 resp_hs_s;

    // Handshake outputs; both forced low while reset is held.
    always_comb begin
        out_free_s   = !valid_out || !stall;
        req_valid_s  = 1'b0;
        resp_ready_s = 1'b0;
        if (!reset) begin
            case (state_r)
                ST_FETCH: req_valid_s  = !redirect;
                ST_WAIT:  resp_ready_s = out_free_s;
                ST_DRAIN: resp_ready_s = 1'b1;  // stale data is always taken
                default: begin
                    req_valid_s  = 1'b0;
                    resp_ready_s = 1'b0;
                end
            endcase
        end else begin
            req_valid_s  = 1'b0;
            resp_ready_s = 1'b0;
        end
    end

    assign icache.icache_req_valid  = req_valid_s;
    assign icache.icache_req_addr   = pc_r;
    assign icache.icache_resp_ready = resp_ready_s;
    assign req_hs_s  = req_valid_s && icache.icache_req_ready;
    assign resp_hs_s = icache.icache_resp_valid && resp_ready_s;

    // Next-state, next-pc and output-register logic; redirect wins over all.
    always_comb begin
        state_nxt_s  = state_r;
        pc_nxt_s     = pc_r;
        pc_out_nxt_s = pc_out;
        // No new instruction written: hold under stall, otherwise retire it.
        if (valid_out && stall) begin
            instr_nxt_s = instr_out;
            valid_nxt_s = 1'b1;
        end else begin
            instr_nxt_s = NOP_INSTR;
            valid_nxt_s = 1'b0;
        end

        if (redirect) begin
            pc_nxt_s    = {redirect_pc[WORD_SIZE-1:2], 2'b00};
            instr_nxt_s = NOP_INSTR;
            valid_nxt_s = 1'b0;
            case (state_r)
                ST_FETCH:          state_nxt_s = ST_FETCH;
                // A response taken this cycle is simply dropped; otherwise
                // the one still in flight must be drained.
                ST_WAIT, ST_DRAIN: state_nxt_s = resp_hs_s ? ST_FETCH : ST_DRAIN;
                default:           state_nxt_s = ST_FETCH;
            endcase
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (req_hs_s) begin
                        state_nxt_s = ST_WAIT;
                    end else begin
                        state_nxt_s = ST_FETCH;
                    end
                end
                ST_WAIT: begin
                    // resp_ready only rises when the output slot is free.
                    if (resp_hs_s) begin
                        instr_nxt_s  = icache.icache_resp_instr;
                        pc_out_nxt_s = pc_r;
                        valid_nxt_s  = 1'b1;
                        pc_nxt_s     = pc_r + PC_STEP;
                        state_nxt_s  = ST_FETCH;
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end
                ST_DRAIN: begin
                    if (resp_hs_s) begin
                        state_nxt_s = ST_FETCH;
                    end else begin
                        state_nxt_s = ST_DRAIN;
                    end
                end
                default: state_nxt_s = ST_FETCH;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_FETCH;
            pc_r      <= BOOT_PC;
            instr_out <= NOP_INSTR;
            pc_out    <= {WORD_SIZE{1'b0}};
            valid_out <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            pc_r      <= pc_nxt_s;
            instr_out <= instr_nxt_s;
            pc_out    <= pc_out_nxt_s;
            valid_out <= valid_nxt_s;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Directed scenarios followed by a randomized run in which a small icache
// model answers requests and a scoreboard queue holds the expected
// (pc, instruction) pairs in fetch order.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        valid_out;

    fetch_stage_if #(.WORD_SIZE(32)) ifc ();

    fetch_stage #(
        .WORD_SIZE (32),
        .BOOT_PC   (32'h0000_1000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .icache      (ifc),
        .instr_out   (instr_out),
        .pc_out      (pc_out),
        .valid_out   (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] sbq[$];
    logic [31:0] exp_pc;
    bit          pend;
    int          cnt;
    logic [31:0] pend_instr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_instr(input logic [31:0] a);
        logic [15:0] lo;
        lo = a[15:0];
        return {lo, ~lo};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One randomized cycle: drive inputs, run the icache model, score outputs.
    task automatic sb_step(input bit rdy, input bit st, input bit rd, input logic [31:0] tgt);
        bit          req_hs;
        bit          resp_hs;
        logic [63:0] e;
        stall                 = st;
        redirect              = rd;
        redirect_pc           = tgt;
        ifc.icache_req_ready  = rdy;
        ifc.icache_resp_valid = pend && (cnt == 0);
        ifc.icache_resp_instr = pend_instr;
        #2;
        req_hs  = ifc.icache_req_valid && rdy;
        resp_hs = ifc.icache_resp_valid && ifc.icache_resp_ready;
        if (pend) check("no_req_while_outstanding", {31'd0, ifc.icache_req_valid}, 32'd0);
        if (valid_out && !st) begin
            if (sbq.size() == 0) begin
                check("sb_unexpected_valid", {31'd0, valid_out}, 32'd0);
            end else begin
                e = sbq.pop_front();
                check("sb_pc", pc_out, e[63:32]);
                check("sb_instr", instr_out, e[31:0]);
            end
        end
        if (resp_hs) pend = 1'b0;
        else if (pend && cnt != 0) cnt--;
        if (req_hs) begin
            check("sb_req_addr", ifc.icache_req_addr, exp_pc);
            sbq.push_back({exp_pc, mk_instr(exp_pc)});
            pend       = 1'b1;
            cnt        = $urandom_range(0, 2);
            pend_instr = mk_instr(ifc.icache_req_addr);
            exp_pc     = exp_pc + 32'd4;
        end
        if (rd) begin
            sbq.delete();
            exp_pc = {tgt[31:2], 2'b00};
        end
        tick();
    endtask

    initial begin
        reset                 = 1'b1;
        stall                 = 1'b0;
        redirect              = 1'b0;
        redirect_pc           = 32'd0;
        ifc.icache_req_ready  = 1'b0;
        ifc.icache_resp_valid = 1'b0;
        ifc.icache_resp_instr = 32'd0;
        repeat (2) @(posedge clk);
        #3;
        check("rst_valid", {31'd0, valid_out}, 32'd0);
        check("rst_instr", instr_out, NOP);
        check("rst_pc_out", pc_out, 32'd0);
        check("rst_req_valid", {31'd0, ifc.icache_req_valid}, 32'd0);
        check("rst_resp_ready", {31'd0, ifc.icache_resp_ready}, 32'd0);
        tick();

        // First fetch after reset: minimum latency.
        reset = 1'b0;
        ifc.icache_req_ready = 1'b1;
        #2;
        check("boot_req_valid", {31'd0, ifc.icache_req_valid}, 32'd1);
        check("boot_req_addr", ifc.icache_req_addr, 32'h0000_1000);
        check("boot_resp_ready", {31'd0, ifc.icache_resp_ready}, 32'd0);
        tick();
        ifc.icache_req_ready  = 1'b0;
        ifc.icache_resp_valid = 1'b1;
        ifc.icache_resp_instr = 32'h0050_0093;
        #2;
        check("wait_resp_ready", {31'd0, ifc.icache_resp_ready}, 32'd1);
        check("wait_req_valid", {31'd0, ifc.icache_req_valid}, 32'd0);
        tick();
        ifc.icache_resp_valid = 1'b0;
        stall = 1'b1;
        ifc.icache_req_ready = 1'b1;
        #2;
        check("first_valid", {31'd0, valid_out}, 32'd1);
        check("first_instr", instr_out, 32'h0050_0093);
        check("first_pc", pc_out, 32'h0000_1000);
        check("next_req_addr", ifc.icache_req_addr, 32'h0000_1004);
        tick();

        // Stall held three cycles with a response pending.
        ifc.icache_req_ready  = 1'b0;
        ifc.icache_resp_valid = 1'b1;
        ifc.icache_resp_instr = 32'h00A0_0113;
        for (int i = 0; i < 3; i++) begin
            #2;
            check("stall_resp_ready", {31'd0, ifc.icache_resp_ready}, 32'd0);
            check("stall_valid", {31'd0, valid_out}, 32'd1);
            check("stall_instr", instr_out, 32'h0050_0093);
            check("stall_pc", pc_out, 32'h0000_1000);
            tick();
        end
        stall = 1'b0;
        #2;
        check("unstall_resp_ready", {31'd0, ifc.icache_resp_ready}, 32'd1);
        tick();
        ifc.icache_resp_valid = 1'b0;
        #2;
        check("second_valid", {31'd0, valid_out}, 32'd1);
        check("second_instr", instr_out, 32'h00A0_0113);
        check("second_pc", pc_out, 32'h0000_1004);
        check("second_req_addr", ifc.icache_req_addr, 32'h0000_1008);
        tick();
        #2;
        check("retired_valid", {31'd0, valid_out}, 32'd0);
        check("retired_instr", instr_out, NOP);

        // Redirect in WAIT, response two cycles later is drained.
        ifc.icache_req_ready = 1'b1;
        tick();
        ifc.icache_req_ready = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_2002;
        #2;
        check("redir_req_valid", {31'd0, ifc.icache_req_valid}, 32'd0);
        tick();
        redirect = 1'b0;
        #2;
        check("drain_resp_ready", {31'd0, ifc.icache_resp_ready}, 32'd1);
        check("drain_req_valid", {31'd0, ifc.icache_req_valid}, 32'd0);
        check("drain_valid", {31'd0, valid_out}, 32'd0);
        tick();
        ifc.icache_resp_valid = 1'b1;
        ifc.icache_resp_instr = 32'hDEAD_BEEF;
        #2;
        check("drain_resp_ready2", {31'd0, ifc.icache_resp_ready}, 32'd1);
        check("drain_valid2", {31'd0, valid_out}, 32'd0);
        tick();
        ifc.icache_resp_valid = 1'b0;
        #2;
        check("post_drain_valid", {31'd0, valid_out}, 32'd0);
        check("post_drain_req_valid", {31'd0, ifc.icache_req_valid}, 32'd1);
        check("post_drain_addr", ifc.icache_req_addr, 32'h0000_2000);

        // Redirect coinciding with a response handshake.
        ifc.icache_req_ready = 1'b1;
        tick();
        ifc.icache_req_ready  = 1'b0;
        ifc.icache_resp_valid = 1'b1;
        ifc.icache_resp_instr = 32'hBAD0_0001;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_3000;
        #2;
        check("coinc_resp_ready", {31'd0, ifc.icache_resp_ready}, 32'd1);
        tick();
        redirect = 1'b0;
        ifc.icache_resp_valid = 1'b0;
        #2;
        check("coinc_valid", {31'd0, valid_out}, 32'd0);
        check("coinc_req_valid", {31'd0, ifc.icache_req_valid}, 32'd1);
        check("coinc_addr", ifc.icache_req_addr, 32'h0000_3000);
        check("coinc_resp_ready_fetch", {31'd0, ifc.icache_resp_ready}, 32'd0);

        // PC wrap at the top of the address space.
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        #1;
        check("redir_fetch_no_req", {31'd0, ifc.icache_req_valid}, 32'd0);
        tick();
        redirect = 1'b0;
        ifc.icache_req_ready = 1'b1;
        #2;
        check("wrap_req_addr", ifc.icache_req_addr, 32'hFFFF_FFFC);
        tick();
        ifc.icache_req_ready  = 1'b0;
        ifc.icache_resp_valid = 1'b1;
        ifc.icache_resp_instr = 32'h0000_0073;
        tick();
        ifc.icache_resp_valid = 1'b0;
        stall = 1'b1;
        ifc.icache_req_ready = 1'b1;
        #2;
        check("wrap_valid", {31'd0, valid_out}, 32'd1);
        check("wrap_pc_out", pc_out, 32'hFFFF_FFFC);
        check("wrap_next_addr", ifc.icache_req_addr, 32'h0000_0000);
        tick();

        // Asynchronous reset in WAIT with a held output.
        ifc.icache_req_ready = 1'b0;
        #2;
        check("pre_rst_valid", {31'd0, valid_out}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("async_rst_valid", {31'd0, valid_out}, 32'd0);
        check("async_rst_instr", instr_out, NOP);
        check("async_rst_pc_out", pc_out, 32'd0);
        check("async_rst_req_valid", {31'd0, ifc.icache_req_valid}, 32'd0);
        check("async_rst_resp_ready", {31'd0, ifc.icache_resp_ready}, 32'd0);
        tick();
        reset = 1'b0;
        stall = 1'b0;
        #2;
        check("post_rst_req_valid", {31'd0, ifc.icache_req_valid}, 32'd1);
        check("post_rst_addr", ifc.icache_req_addr, 32'h0000_1000);
        check("post_rst_resp_ready", {31'd0, ifc.icache_resp_ready}, 32'd0);
        tick();

        // Randomized run against the scoreboard.
        exp_pc     = 32'h0000_1000;
        pend       = 1'b0;
        cnt        = 0;
        pend_instr = 32'd0;
        for (int i = 0; i < 400; i++) begin
            sb_step($urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 11) == 0, $urandom);
        end
        for (int i = 0; i < 10; i++) begin
            sb_step(1'b0, 1'b0, 1'b0, 32'd0);
        end
        check("sb_drained", sbq.size(), 32'd0);
        check("sb_final_valid", {31'd0, valid_out}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
